// File: rtl/sr_drive_ctrl.sv
// SR latch command stage: synchronise, debounce and edge-detect set/clear requests, then issue exclusive s/r pulses.
// Optional expected-latch-state outputs q_exp/q_exp_bar are enabled by defining SR_DRIVE_MIRROR_EN.
module sr_drive_ctrl #(
  parameter int DEB_CYCLES   = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1,
  parameter int CW           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  output logic s,
  output logic r,
  output logic busy,
  output logic err
`ifdef SR_DRIVE_MIRROR_EN
  ,
  output logic q_exp,
  output logic q_exp_bar
`endif
);

  typedef enum logic [1:0] {IDLE, SET_P, CLR_P, GAP} state_t;

  localparam logic [CW-1:0] DEB_LIM   = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LIM = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0] GAP_LIM   = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] ONE       = CW'(1);

  logic [1:0]    req, sync1, sync2, level, level_d, ev;
  logic [CW-1:0] deb_cnt [2];
  state_t        state;
  logic [CW-1:0] cnt;
  logic          set_pend, clr_pend;
  logic          set_ev, clr_ev, both_ev, idle;
  logic          take_clr, take_set, clr_left, set_left, clr_new, set_new;

  // bit 0 carries the set request, bit 1 the clear request
  assign req = {clr_req, set_req};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      ev      <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1   <= req;
      sync2   <= sync1;
      level_d <= level;
      ev      <= level & ~level_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != level[i]) begin
          if (deb_cnt[i] >= DEB_LIM) begin
            level[i]   <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + ONE;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // An event not serviced directly lands in its pending slot; a slot still occupied drops it.
  assign set_ev   = ev[0];
  assign clr_ev   = ev[1];
  assign both_ev  = set_ev & clr_ev;
  assign idle     = (state == IDLE);
  assign take_clr = idle & (clr_pend | (clr_ev & ~both_ev));
  assign take_set = idle & ~take_clr & (set_pend | (set_ev & ~both_ev));
  assign clr_left = clr_pend & ~take_clr;
  assign set_left = set_pend & ~take_set;
  assign clr_new  = clr_ev & ~both_ev & ~(take_clr & ~clr_pend);
  assign set_new  = set_ev & ~both_ev & ~(take_set & ~set_pend);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      s        <= 1'b0;
      r        <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      set_pend <= 1'b0;
      clr_pend <= 1'b0;
`ifdef SR_DRIVE_MIRROR_EN
      q_exp    <= 1'b0;
`endif
    end else begin
      clr_pend <= clr_left | clr_new;
      set_pend <= set_left | set_new;
      err      <= both_ev | (clr_left & clr_new) | (set_left & set_new);
      case (state)
        IDLE: begin
          if (take_clr) begin
            state <= CLR_P;
            r     <= 1'b1;
            busy  <= 1'b1;
            cnt   <= ONE;
          end else if (take_set) begin
            state <= SET_P;
            s     <= 1'b1;
            busy  <= 1'b1;
            cnt   <= ONE;
          end
        end
        SET_P, CLR_P: begin
          if (cnt >= PULSE_LIM) begin
            s <= 1'b0;
            r <= 1'b0;
`ifdef SR_DRIVE_MIRROR_EN
            q_exp <= (state == SET_P);
`endif
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
              cnt   <= '0;
            end else begin
              state <= GAP;
              cnt   <= ONE;
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
        GAP: begin
          if (cnt >= GAP_LIM) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SR_DRIVE_MIRROR_EN
  assign q_exp_bar = ~q_exp;
`endif

endmodule
